cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_if.sv | 24 ++
 rtl/cache_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Generic cache-style memory bus: requester holds addr/data/strobes
// until the responder drops busy for one completion cycle.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] byte_en;
    logic                ren;
    logic                wen;
    logic [DATA_W-1:0]   rdata;
    logic                busy;

    modport master (
        output addr, wdata, byte_en, ren, wen,
        input  rdata, busy
    );

    modport slave (
        input  addr, wdata, byte_en, ren, wen,
        output rdata, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter merging the I$ and D$ memory buses onto one
// downstream bus, with a saturating count of contention cycles.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   i_bus,
    cache_mem_arbiter_if.slave   d_bus,
    cache_mem_arbiter_if.master  m_bus,
    output logic [31:0]          conflict_cnt
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic        i_req, d_req;
    logic        conflict;

    assign i_req = i_bus.ren | i_bus.wen;
    assign d_req = d_bus.ren | d_bus.wen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // last_q: 0 = I side granted last, 1 = D side
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = last_q ? SERVE_I : SERVE_D;
                    last_d  = ~last_q;
                end else if (i_req) begin
                    state_d = SERVE_I;
                    last_d  = 1'b0;
                end else if (d_req) begin
                    state_d = SERVE_D;
                    last_d  = 1'b1;
                end
            end
            SERVE_I: begin
                if (!i_req || !m_bus.busy) state_d = IDLE;
            end
            SERVE_D: begin
                if (!d_req || !m_bus.busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign conflict = ((state_q == SERVE_I) && d_req) ||
                      ((state_q == SERVE_D) && i_req);

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    assign conflict_cnt = cnt_q;

    always_comb begin
        m_bus.addr    = {ADDR_W{1'b0}};
        m_bus.wdata   = {DATA_W{1'b0}};
        m_bus.byte_en = {BE_W{1'b0}};
        m_bus.ren     = 1'b0;
        m_bus.wen     = 1'b0;
        i_bus.busy    = 1'b1;
        i_bus.rdata   = {DATA_W{1'b0}};
        d_bus.busy    = 1'b1;
        d_bus.rdata   = {DATA_W{1'b0}};
        unique case (state_q)
            SERVE_I: begin
                if (i_req) begin
                    m_bus.addr    = i_bus.addr;
                    m_bus.wdata   = i_bus.wdata;
                    m_bus.byte_en = i_bus.byte_en;
                    m_bus.wen     = i_bus.wen;
                    m_bus.ren     = i_bus.ren & ~i_bus.wen;
                    if (!m_bus.busy) begin
                        i_bus.busy  = 1'b0;
                        i_bus.rdata = m_bus.rdata;
                    end
                end
            end
            SERVE_D: begin
                if (d_req) begin
                    m_bus.addr    = d_bus.addr;
                    m_bus.wdata   = d_bus.wdata;
                    m_bus.byte_en = d_bus.byte_en;
                    m_bus.wen     = d_bus.wen;
                    m_bus.ren     = d_bus.ren & ~d_bus.wen;
                    if (!m_bus.busy) begin
                        d_bus.busy  = 1'b0;
                        d_bus.rdata = m_bus.rdata;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table plus hand-written
// sequences for alternation, mid-transaction reset and saturation.
module tb_cache_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic [31:0] conflict_cnt;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_bus ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_bus ();
    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .i_bus        (i_bus),
        .d_bus        (d_bus),
        .m_bus        (m_bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] IW = 32'h5555_0000;

    typedef struct {
        logic        ir, iw;
        logic [31:0] ia, iwd;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic        mb;
        logic [31:0] mrd;
        logic        er, ew;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        logic        ib, db;
        logic [31:0] ird, drd, ecnt;
    } vec_t;

    vec_t vecs[19];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic ir, iw, input logic [31:0] ia, iwd,
        input logic dr, dw, input logic [31:0] da, dwd,
        input logic mb, input logic [31:0] mrd,
        input logic er, ew, input logic [31:0] ea, ewd,
        input logic [3:0] ebe, input logic ib, db,
        input logic [31:0] ird, drd, ecnt);
        vec_t r;
        r.ir = ir; r.iw = iw; r.ia = ia; r.iwd = iwd;
        r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd;
        r.mb = mb; r.mrd = mrd;
        r.er = er; r.ew = ew; r.ea = ea; r.ewd = ewd; r.ebe = ebe;
        r.ib = ib; r.db = db; r.ird = ird; r.drd = drd; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic drive(input logic ir, iw, input logic [31:0] ia,
                         input logic dr, dw, input logic [31:0] da, dwd,
                         input logic mb, input logic [31:0] mrd);
        i_bus.ren = ir; i_bus.wen = iw; i_bus.addr = ia; i_bus.wdata = IW;
        d_bus.ren = dr; d_bus.wen = dw; d_bus.addr = da; d_bus.wdata = dwd;
        m_bus.busy = mb; m_bus.rdata = mrd;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_pat;
        logic       act, mb;
        int         svc, n;
        logic       exp_side[4];

        i_bus.byte_en = 4'hF;
        d_bus.byte_en = 4'h3;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

        vecs[0]  = v(0,0,32'h000,IW, 0,0,32'h000,0, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,0);
        vecs[1]  = v(1,0,32'h100,IW, 0,0,32'h999,0, 1,32'hDEAD_BEEF,
                     0,0,0,0,4'h0, 1,1,0,0,0);
        vecs[2]  = v(1,0,32'h100,IW, 0,0,32'h999,0, 1,32'hDEAD_BEEF,
                     1,0,32'h100,IW,4'hF, 1,1,0,0,0);
        vecs[3]  = v(1,0,32'h100,IW, 0,0,32'h999,0, 0,32'hDEAD_BEEF,
                     1,0,32'h100,IW,4'hF, 0,1,32'hDEAD_BEEF,0,0);
        vecs[4]  = v(0,0,32'h100,IW, 0,0,32'h999,0, 0,0,
                     0,0,0,0,4'h0, 1,1,0,0,0);
        vecs[5]  = v(1,0,32'h200,IW, 0,1,32'h300,32'h1234_5678, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,0);
        vecs[6]  = v(1,0,32'h200,IW, 0,1,32'h300,32'h1234_5678, 1,0,
                     0,1,32'h300,32'h1234_5678,4'h3, 1,1,0,0,0);
        vecs[7]  = v(1,0,32'h200,IW, 0,1,32'h300,32'h1234_5678,
                     0,32'hAAAA_5555,
                     0,1,32'h300,32'h1234_5678,4'h3,
                     1,0,0,32'hAAAA_5555,1);
        vecs[8]  = v(1,0,32'h200,IW, 0,0,32'h300,32'h1234_5678, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,2);
        vecs[9]  = v(1,0,32'h200,IW, 0,0,32'h300,32'h1234_5678,
                     0,32'h0BAD_F00D,
                     1,0,32'h200,IW,4'hF, 0,1,32'h0BAD_F00D,0,2);
        vecs[10] = v(0,0,32'h200,IW, 1,1,32'h400,32'hCAFE_0000, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,2);
        vecs[11] = v(0,0,32'h200,IW, 1,1,32'h400,32'hCAFE_0000, 1,0,
                     0,1,32'h400,32'hCAFE_0000,4'h3, 1,1,0,0,2);
        vecs[12] = v(1,0,32'h500,IW, 0,0,32'h400,32'hCAFE_0000,
                     0,32'h7777_7777,
                     0,0,0,0,4'h0, 1,1,0,0,2);
        vecs[13] = v(1,0,32'h500,IW, 0,0,32'h400,32'hCAFE_0000, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,3);
        vecs[14] = v(1,0,32'h500,IW, 1,0,32'h600,0, 1,0,
                     1,0,32'h500,IW,4'hF, 1,1,0,0,3);
        vecs[15] = v(1,0,32'h500,IW, 1,0,32'h600,0, 0,32'h1111_2222,
                     1,0,32'h500,IW,4'hF, 0,1,32'h1111_2222,0,4);
        vecs[16] = v(0,0,32'h500,IW, 1,0,32'h600,0, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,5);
        vecs[17] = v(0,0,32'h500,IW, 1,0,32'h600,0, 0,32'h3333_4444,
                     1,0,32'h600,0,4'h3, 1,0,0,32'h3333_4444,5);
        vecs[18] = v(0,0,0,IW, 0,0,0,0, 1,0,
                     0,0,0,0,4'h0, 1,1,0,0,5);

        // Reset state, checked while nRST is still low
        @(negedge CLK);
        #1;
        chk("rst.m_ren", {31'd0, m_bus.ren}, 0);
        chk("rst.m_wen", {31'd0, m_bus.wen}, 0);
        chk("rst.m_addr", m_bus.addr, 0);
        chk("rst.i_busy", {31'd0, i_bus.busy}, 1);
        chk("rst.d_busy", {31'd0, d_bus.busy}, 1);
        chk("rst.cnt", conflict_cnt, 0);
        nRST = 1'b1;

        for (int k = 0; k < 19; k++) begin
            @(negedge CLK);
            drive(vecs[k].ir, vecs[k].iw, vecs[k].ia,
                  vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].dwd,
                  vecs[k].mb, vecs[k].mrd);
            #1;
            chk($sformatf("v%0d.m_ren", k), {31'd0, m_bus.ren},
                {31'd0, vecs[k].er});
            chk($sformatf("v%0d.m_wen", k), {31'd0, m_bus.wen},
                {31'd0, vecs[k].ew});
            chk($sformatf("v%0d.m_addr", k), m_bus.addr, vecs[k].ea);
            chk($sformatf("v%0d.m_wdata", k), m_bus.wdata, vecs[k].ewd);
            chk($sformatf("v%0d.m_be", k), {28'd0, m_bus.byte_en},
                {28'd0, vecs[k].ebe});
            chk($sformatf("v%0d.i_busy", k), {31'd0, i_bus.busy},
                {31'd0, vecs[k].ib});
            chk($sformatf("v%0d.d_busy", k), {31'd0, d_bus.busy},
                {31'd0, vecs[k].db});
            chk($sformatf("v%0d.i_rdata", k), i_bus.rdata, vecs[k].ird);
            chk($sformatf("v%0d.d_rdata", k), d_bus.rdata, vecs[k].drd);
            chk($sformatf("v%0d.cnt", k), conflict_cnt, vecs[k].ecnt);
        end

        // Both sides always requesting, 3-cycle downstream accesses
        do_reset();
        exp_side[0] = 1'b1; exp_side[1] = 1'b0;
        exp_side[2] = 1'b1; exp_side[3] = 1'b0;
        svc = 0;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge CLK);
            mb = (svc == 2) ? 1'b0 : 1'b1;
            drive(1, 0, 32'h800, 1, 0, 32'h900, 0, mb, 32'h4242_0000);
            #1;
            act = m_bus.ren | m_bus.wen;
            if (!i_bus.busy || !d_bus.busy) begin
                exp_pat = exp_side[n] ? 2'b10 : 2'b01;
                chk($sformatf("alt%0d.busy", n),
                    {30'd0, i_bus.busy, d_bus.busy}, {30'd0, exp_pat});
                chk($sformatf("alt%0d.mb", n), {31'd0, mb}, 0);
                n++;
            end else if (act && !mb) begin
                chk($sformatf("alt%0d.missing", n), 1, 0);
            end
            if (act && mb) svc++;
            else svc = 0;
        end
        chk("alt.count", n, 4);

        // Reset pulsed in the middle of an I$ access
        do_reset();
        @(negedge CLK);
        drive(1, 0, 32'h700, 0, 0, 32'h0, 0, 1, 0);
        @(negedge CLK);
        drive(1, 0, 32'h700, 1, 0, 32'hB00, 0, 1, 0);
        #1;
        chk("mid.m_ren", {31'd0, m_bus.ren}, 1);
        @(negedge CLK);
        #1;
        chk("mid.cnt", conflict_cnt, 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("mid.rst_m_ren", {31'd0, m_bus.ren}, 0);
        chk("mid.rst_m_addr", m_bus.addr, 0);
        chk("mid.rst_i_busy", {31'd0, i_bus.busy}, 1);
        chk("mid.rst_cnt", conflict_cnt, 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_0000);
        #1;
        chk("mid.hold_i_busy", {31'd0, i_bus.busy}, 1);
        nRST = 1'b1;
        @(negedge CLK);
        drive(1, 0, 32'hA00, 0, 0, 0, 0, 0, 32'hFFFF_0000);
        #1;
        chk("mid.idle_m_ren", {31'd0, m_bus.ren}, 0);
        chk("mid.idle_i_busy", {31'd0, i_bus.busy}, 1);
        chk("mid.idle_cnt", conflict_cnt, 0);

        // Counter saturation under a held conflict
        do_reset();
        @(negedge CLK);
        drive(1, 0, 32'hC00, 1, 0, 32'hD00, 0, 1, 0);
        @(negedge CLK);
        #1;
        chk("sat.m_addr", m_bus.addr, 32'hD00);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        #1;
        chk("sat.start", conflict_cnt, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("sat.c%0d", k), conflict_cnt, 32'hFFFF_FFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
